rf80386_pic: RTL and testbench

//  Bus-responder interrupt controller for the rf80386 core; the slave end of the CPU's I/O and interrupt-acknowledge cycles.

---
 rtl/rf80386_pkg.sv | 22 ++
 rtl/rf80386_pic_prio.sv | 18 +
 rtl/rf80386_pic.sv | 160 ++++++++++++++++
 tb/tb_rf80386_pic.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf80386_pkg.sv
// Shared rf80386 bus cycle-type codes and interrupt-controller types.
// The PIC and the core's bus interface both import this package.
package rf80386_pkg;

  localparam logic [3:0] CT_PASSIVE = 4'h0;
  localparam logic [3:0] CT_INTA    = 4'h1;
  localparam logic [3:0] CT_RDIO    = 4'h2;
  localparam logic [3:0] CT_WRIO    = 4'h3;

  typedef enum logic {
    PIC_IDLE  = 1'b0,
    PIC_INTA1 = 1'b1
  } pic_state_t;

  localparam logic [7:0] PIC_EOI_NS = 8'h20;
  localparam logic [4:0] PIC_EOI_SP = 5'b01100;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

endpackage

// File: rtl/rf80386_pic_prio.sv
// Lowest-set-bit encoder: bit 0 is the highest interrupt priority.
module rf80386_pic_prio (
  input  logic [7:0] vec,
  output logic       valid,
  output logic [2:0] idx
);

  // scanning downwards so the lowest set bit wins
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      valid = valid | vec[i];
      idx   = vec[i] ? 3'(i) : idx;
    end
  end

endmodule

// File: rtl/rf80386_pic.sv
// rf80386 interrupt controller: request latching, priority resolution,
// two-cycle INTA vector delivery and an I/O-mapped register file.
module rf80386_pic
  import rf80386_pkg::*;
#(
  parameter logic [15:0] IO_BASE     = 16'h0020,
  parameter logic [4:0]  VBASE_RESET = 5'h01,
  parameter logic [7:0]  ELCR_RESET  = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  cyc_type_i,
  input  logic [15:0] adr_i,
  input  logic [7:0]  dat_i,
  output logic [7:0]  dat_o,
  output logic        ack_o,
  input  logic [7:0]  irq_i,
  output logic        irq_o
);

  logic [7:0] sync1, sync2, sync3;
  logic [7:0] irr, isr, imr, elcr, pend;
  logic [7:0] irr_nx, isr_set, isr_clr, irr_clr, rdata, fire_data;
  logic [4:0] vbase;
  logic [2:0] lvl, lvl_nx, pend_idx, isr_idx;
  logic       pend_v, isr_v;
  logic       is_inta, is_io, hit, sel, fire, inta_fire, wr, rd, ack_nx;
  pic_state_t state, state_nx;

  assign pend = irr & ~imr;

  rf80386_pic_prio u_pend_prio (.vec(pend), .valid(pend_v), .idx(pend_idx));
  rf80386_pic_prio u_isr_prio  (.vec(isr),  .valid(isr_v),  .idx(isr_idx));

  assign is_inta   = (cyc_type_i == CT_INTA);
  assign is_io     = (cyc_type_i == CT_RDIO) | (cyc_type_i == CT_WRIO);
  assign hit       = (adr_i[15:3] == IO_BASE[15:3]);
  assign sel       = cyc_i & stb_i & ((is_io & hit) | is_inta);
  assign fire      = sel & ~ack_o;
  assign inta_fire = fire & is_inta;
  assign wr        = fire & is_io & hit & we_i;
  assign rd        = fire & is_io & hit & ~we_i;
  assign ack_nx    = ack_o ? (cyc_i & stb_i) : sel;

  // a fresh edge always wins over a same-cycle clear; level lines just follow the input
  assign irr_nx = (elcr & sync2) | (~elcr & ((irr & ~irr_clr) | (sync2 & ~sync3)));

  // register read mux
  always_comb begin
    case (adr_i[2:0])
      3'd0:    rdata = irr;
      3'd1:    rdata = imr;
      3'd2:    rdata = isr;
      3'd3:    rdata = {vbase, 3'b000};
      3'd4:    rdata = elcr;
      default: rdata = 8'hFF;
    endcase
  end

  // end-of-interrupt command decode
  always_comb begin
    isr_clr = 8'h00;
    if (wr && (adr_i[2:0] == 3'd0)) begin
      if (dat_i == PIC_EOI_NS) begin
        isr_clr = isr_v ? onehot8(isr_idx) : 8'h00;
      end else if (dat_i[7:3] == PIC_EOI_SP) begin
        isr_clr = onehot8(dat_i[2:0]);
      end else begin
        isr_clr = 8'h00;
      end
    end else begin
      isr_clr = 8'h00;
    end
  end

  // INTA sequencing and response data selection
  always_comb begin
    state_nx  = state;
    lvl_nx    = lvl;
    isr_set   = 8'h00;
    irr_clr   = 8'h00;
    fire_data = 8'hFF;
    if (inta_fire) begin
      case (state)
        PIC_IDLE: begin
          state_nx  = PIC_INTA1;
          lvl_nx    = pend_v ? pend_idx : 3'd7;
          isr_set   = pend_v ? onehot8(pend_idx) : 8'h00;
          irr_clr   = isr_set & ~elcr;
          fire_data = 8'hFF;
        end
        PIC_INTA1: begin
          state_nx  = PIC_IDLE;
          fire_data = {vbase, lvl};
        end
        default: state_nx = PIC_IDLE;
      endcase
    end else if (rd) begin
      fire_data = rdata;
    end else begin
      fire_data = 8'hFF;
    end
  end

  // request synchroniser with one extra stage of edge history
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
      sync3 <= 8'h00;
    end else begin
      sync1 <= irq_i;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // controller state and programmable registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irr   <= 8'h00;
      isr   <= 8'h00;
      imr   <= 8'hFF;
      elcr  <= ELCR_RESET;
      vbase <= VBASE_RESET;
      state <= PIC_IDLE;
      lvl   <= 3'd0;
    end else begin
      irr   <= irr_nx;
      isr   <= (isr | isr_set) & ~isr_clr;
      state <= state_nx;
      lvl   <= lvl_nx;
      if (wr) begin
        case (adr_i[2:0])
          3'd1:    imr   <= dat_i;
          3'd3:    vbase <= dat_i[7:3];
          3'd4:    elcr  <= dat_i;
          default: imr   <= imr;
        endcase
      end
    end
  end

  // registered bus and interrupt outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_o <= 1'b0;
      dat_o <= 8'hFF;
      irq_o <= 1'b0;
    end else begin
      ack_o <= ack_nx;
      dat_o <= fire ? fire_data : (ack_nx ? dat_o : 8'hFF);
      irq_o <= pend_v & (~isr_v | (pend_idx < isr_idx));
    end
  end

endmodule

// File: tb/tb_rf80386_pic.sv
// Self-checking bench for rf80386_pic: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the controller.
module tb_rf80386_pic;
  import rf80386_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [3:0]  cyc_type_i = 4'h0;
  logic [15:0] adr_i = 16'h0000;
  logic [7:0]  dat_i = 8'h00, irq_i = 8'h00;
  logic [7:0]  dat_o;
  logic        ack_o, irq_o;

  int checks = 0, failures = 0, ack_rises = 0;
  logic rand_irq = 1'b0;
  logic prev_ack = 1'b0;

  rf80386_pic dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .cyc_type_i(cyc_type_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .ack_o(ack_o), .irq_i(irq_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // behavioural model
  logic [7:0] m_p1, m_p2, m_p3, m_irr, m_isr, m_imr, m_elcr, m_dat;
  logic [4:0] m_vbase;
  logic [2:0] m_lvl;
  logic       m_mid, m_ack, m_irq;

  function automatic int lowest(input logic [7:0] v);
    int r = 8;
    for (int i = 7; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin : model
    logic [7:0] n_irr, n_isr, pend;
    logic sel, fire;
    int w, l;
    if (!rst_ni) begin
      m_p1 = 8'h00; m_p2 = 8'h00; m_p3 = 8'h00;
      m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'hFF; m_elcr = 8'h00;
      m_vbase = 5'h01; m_lvl = 3'd0; m_mid = 1'b0;
      m_ack = 1'b0; m_dat = 8'hFF; m_irq = 1'b0;
    end else begin
      pend = m_irr & ~m_imr;
      sel = cyc_i && stb_i && ((((cyc_type_i == CT_RDIO) || (cyc_type_i == CT_WRIO))
            && (adr_i[15:3] == 13'h0004)) || (cyc_type_i == CT_INTA));
      fire = sel && !m_ack;
      for (int i = 0; i < 8; i++)
        n_irr[i] = m_elcr[i] ? m_p2[i] : (m_irr[i] | (m_p2[i] & ~m_p3[i]));
      n_isr = m_isr;
      m_irq = lowest(pend) < lowest(m_isr);
      m_ack = m_ack ? (cyc_i && stb_i) : sel;
      if (!m_ack) m_dat = 8'hFF;
      if (fire) begin
        m_dat = 8'hFF;
        if (cyc_type_i == CT_INTA) begin
          if (!m_mid) begin
            w = lowest(pend);
            m_lvl = 3'd7;
            if (w < 8) begin
              m_lvl = 3'(w);
              n_isr[w] = 1'b1;
              if (!m_elcr[w]) n_irr[w] = m_p2[w] & ~m_p3[w];
            end
            m_mid = 1'b1;
          end else begin
            m_dat = {m_vbase, m_lvl};
            m_mid = 1'b0;
          end
        end else if (we_i) begin
          case (adr_i[2:0])
            3'd0: begin
              if (dat_i == 8'h20) begin
                l = lowest(m_isr);
                if (l < 8) n_isr[l] = 1'b0;
              end else if (dat_i[7:3] == 5'b01100) n_isr[dat_i[2:0]] = 1'b0;
            end
            3'd1: m_imr = dat_i;
            3'd3: m_vbase = dat_i[7:3];
            3'd4: m_elcr = dat_i;
            default: ;
          endcase
        end else begin
          case (adr_i[2:0])
            3'd0: m_dat = m_irr;
            3'd1: m_dat = m_imr;
            3'd2: m_dat = m_isr;
            3'd3: m_dat = {m_vbase, 3'b000};
            3'd4: m_dat = m_elcr;
            default: m_dat = 8'hFF;
          endcase
        end
      end
      m_irr = n_irr;
      m_isr = n_isr;
      m_p3 = m_p2; m_p2 = m_p1; m_p1 = irq_i;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("ack", {7'd0, ack_o}, {7'd0, m_ack});
      chk("dat", dat_o, m_dat);
      chk("irq", {7'd0, irq_o}, {7'd0, m_irq});
      if (ack_o && !prev_ack) ack_rises++;
    end
    prev_ack = ack_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rand_irq && ($urandom_range(0, 5) == 0)) irq_i[$urandom_range(0, 7)] ^= 1'b1;
  endtask

  task automatic bus(input logic inta, input logic wr, input logic [15:0] adr,
                     input logic [7:0] d, input int hold, output logic [7:0] rd);
    logic got = 1'b0;
    rd = 8'h00;
    tick();
    cyc_i = 1'b1; stb_i = 1'b1; we_i = wr & ~inta; adr_i = adr; dat_i = d;
    cyc_type_i = inta ? CT_INTA : (wr ? CT_WRIO : CT_RDIO);
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk_i);
      if (ack_o) begin got = 1'b1; rd = dat_o; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL bus_timeout actual=no_ack required=ack adr=%h", adr);
    end
    repeat (hold) tick();
    tick();
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cyc_type_i = CT_PASSIVE;
  endtask

  task automatic wr_io(input logic [15:0] adr, input logic [7:0] d);
    logic [7:0] r;
    bus(1'b0, 1'b1, adr, d, 0, r);
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] adr, input logic [7:0] exp);
    logic [7:0] r;
    bus(1'b0, 1'b0, adr, 8'h00, 0, r);
    chk(nm, r, exp);
  endtask

  task automatic inta_pair(input string nm, input logic [7:0] exp_vec);
    logic [7:0] r;
    bus(1'b1, 1'b0, 16'h0000, 8'h00, 0, r);
    chk({nm, "_inta1"}, r, 8'hFF);
    bus(1'b1, 1'b0, 16'h0000, 8'h00, 0, r);
    chk({nm, "_vec"}, r, exp_vec);
  endtask

  task automatic wait_irq(input string nm);
    logic seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      @(negedge clk_i);
      seen = irq_o;
    end
    chk(nm, {7'd0, seen}, 8'h01);
  endtask

  task automatic pulse(input logic [7:0] m);
    irq_i = irq_i | m;
    tick(); tick();
    irq_i = irq_i & ~m;
  endtask

  initial begin
    logic [7:0] r;
    int r0, op;
    repeat (3) tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_dat", dat_o, 8'hFF);
    chk("rst_irq", {7'd0, irq_o}, 8'h00);
    // 1: reset register values
    rd_chk("imr_rst", 16'h0021, 8'hFF);
    rd_chk("vbase_rst", 16'h0023, 8'h08);
    rd_chk("irr_rst", 16'h0020, 8'h00);
    // 2: single edge request and INTA pair
    wr_io(16'h0021, 8'hFE);
    pulse(8'h01);
    wait_irq("irq_l0");
    inta_pair("l0", 8'h08);
    rd_chk("isr_l0", 16'h0022, 8'h01);
    rd_chk("irr_l0", 16'h0020, 8'h00);
    chk("irq_after_l0", {7'd0, irq_o}, 8'h00);
    wr_io(16'h0020, 8'h20);
    // 3: nesting and EOI flavours
    wr_io(16'h0021, 8'h00);
    pulse(8'h08);
    wait_irq("irq_l3");
    inta_pair("l3", 8'h0B);
    pulse(8'h22);
    wait_irq("irq_l1");
    inta_pair("l1", 8'h09);
    rd_chk("isr_nest", 16'h0022, 8'h0A);
    wr_io(16'h0020, 8'h20);
    rd_chk("isr_ns_eoi", 16'h0022, 8'h08);
    repeat (3) tick();
    chk("irq_blocked", {7'd0, irq_o}, 8'h00);
    wr_io(16'h0020, 8'h63);
    wait_irq("irq_l5");
    inta_pair("l5", 8'h0D);
    wr_io(16'h0020, 8'h20);
    rd_chk("isr_clear", 16'h0022, 8'h00);
    // 4: level request withdrawn before INTA is spurious
    wr_io(16'h0024, 8'h04);
    irq_i[2] = 1'b1;
    wait_irq("irq_lvl2");
    irq_i[2] = 1'b0;
    repeat (4) tick();
    inta_pair("spur", 8'h0F);
    rd_chk("isr_spur", 16'h0022, 8'h00);
    wr_io(16'h0024, 8'h00);
    // 5: long strobe gives one ack
    r0 = ack_rises;
    bus(1'b0, 1'b1, 16'h0021, 8'h5A, 3, r);
    tick();
    @(negedge clk_i);
    chk("ack_drop", {7'd0, ack_o}, 8'h00);
    chk("ack_once", 8'(ack_rises - r0), 8'h01);
    rd_chk("imr_hold", 16'h0021, 8'h5A);
    // 6: reset in the middle of an INTA sequence
    wr_io(16'h0021, 8'h00);
    pulse(8'h10);
    wait_irq("irq_l4");
    bus(1'b1, 1'b0, 16'h0000, 8'h00, 0, r);
    chk("mid_inta1", r, 8'hFF);
    tick(); rst_ni = 1'b0;
    tick(); rst_ni = 1'b1;
    rd_chk("imr_rst2", 16'h0021, 8'hFF);
    rd_chk("isr_rst2", 16'h0022, 8'h00);
    rd_chk("vbase_rst2", 16'h0023, 8'h08);
    wr_io(16'h0021, 8'h00);
    pulse(8'h40);
    wait_irq("irq_l6");
    inta_pair("fresh", 8'h0E);
    // random traffic, checked by the model every cycle
    rand_irq = 1'b1;
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1: bus(1'b0, 1'b0, 16'h0020 + 16'($urandom_range(0, 7)), 8'h00, $urandom_range(0, 2), r);
        2: wr_io(16'h0021, 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)));
        3: wr_io(16'h0024, 8'($urandom_range(0, 255)));
        4: wr_io(16'h0023, 8'($urandom_range(0, 255)));
        5: wr_io(16'h0020, ($urandom_range(0, 1) == 0) ? 8'h20 : (8'h60 | 8'($urandom_range(0, 7))));
        6, 7: bus(1'b1, 1'b0, 16'h0000, 8'h00, $urandom_range(0, 2), r);
        8: begin
          tick();
          cyc_i = 1'b1; stb_i = 1'b1; cyc_type_i = CT_RDIO; adr_i = 16'h0040;
          tick(); tick();
          cyc_i = 1'b0; stb_i = 1'b0; cyc_type_i = CT_PASSIVE;
        end
        default: repeat ($urandom_range(1, 4)) tick();
      endcase
    end
    rand_irq = 1'b0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
